// File: rtl/timer_apb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : timer_apb_arbiter
// Brief    : Two-client round-robin APB master for the timer_top slave port.
//            Optional ACCESS wait limit enabled by TIMER_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module timer_apb_arbiter #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_done,
    output logic [DATA_W-1:0] req0_rdata,
    output logic              req0_err,
    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_done,
    output logic [DATA_W-1:0] req1_rdata,
    output logic              req1_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    output logic              busy,
    output logic              grant_id
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SETUP  = 2'd1;
    localparam logic [1:0] c_ACCESS = 2'd2;
    localparam logic [1:0] c_DONE   = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic              r_prio;
    logic              r_grant_id;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;
    logic              w_any_req;
    logic              w_grant_sel;
    logic              w_timeout;

    if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255) begin : g_bad_timeout_cyc
        $error("timer_apb_arbiter: TIMEOUT_CYC must be within 2..255");
    end

    assign w_any_req   = req0_valid | req1_valid;
    // r_prio names the client that wins when both request together.
    assign w_grant_sel = (req0_valid & req1_valid) ? r_prio : req1_valid;

`ifdef TIMER_ARB_TIMEOUT_EN
    localparam logic [7:0] c_WAIT_LAST = 8'(TIMEOUT_CYC - 1);

    logic [7:0] r_wait_cnt;

    always_ff @(posedge pclk) begin
        if (preset || r_state != c_ACCESS) begin
            r_wait_cnt <= 8'd0;
        end else if (!pready) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end
    end

    assign w_timeout = (r_state == c_ACCESS) && !pready && (r_wait_cnt == c_WAIT_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:   if (w_any_req) w_next_state = c_SETUP;
            c_SETUP:  w_next_state = c_ACCESS;
            c_ACCESS: if (pready || w_timeout) w_next_state = c_DONE;
            c_DONE:   w_next_state = c_IDLE;
            default:  w_next_state = c_IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_prio     <= 1'b0;
            r_grant_id <= 1'b0;
            r_pwrite   <= 1'b0;
            r_paddr    <= '0;
            r_pwdata   <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
        end else begin
            if (r_state == c_IDLE && w_any_req) begin
                r_grant_id <= w_grant_sel;
                r_prio     <= ~w_grant_sel;
                r_pwrite   <= w_grant_sel ? req1_write : req0_write;
                r_paddr    <= w_grant_sel ? req1_addr  : req0_addr;
                r_pwdata   <= w_grant_sel ? req1_wdata : req0_wdata;
                r_rdata    <= '0;
                r_err      <= 1'b0;
            end
            // pready wins over a timeout landing in the same cycle.
            if (r_state == c_ACCESS) begin
                if (pready) begin
                    r_rdata <= r_pwrite ? '0 : prdata;
                    r_err   <= 1'b0;
                end else if (w_timeout) begin
                    r_rdata <= '0;
                    r_err   <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        psel       = 1'b0;
        penable    = 1'b0;
        req0_done  = 1'b0;
        req0_rdata = '0;
        req0_err   = 1'b0;
        req1_done  = 1'b0;
        req1_rdata = '0;
        req1_err   = 1'b0;
        case (r_state)
            c_SETUP: psel = 1'b1;
            c_ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
            end
            c_DONE: begin
                if (r_grant_id) begin
                    req1_done  = 1'b1;
                    req1_rdata = r_rdata;
                    req1_err   = r_err;
                end else begin
                    req0_done  = 1'b1;
                    req0_rdata = r_rdata;
                    req0_err   = r_err;
                end
            end
            default: ;
        endcase
    end

    assign busy     = (r_state != c_IDLE);
    assign grant_id = r_grant_id;
    assign pwrite   = r_pwrite;
    assign paddr    = r_paddr;
    assign pwdata   = r_pwdata;

endmodule
`default_nettype wire

// File: tb/tb_timer_apb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_timer_apb_arbiter
// Brief    : Directed and randomized bench for timer_apb_arbiter with a
//            transaction-level reference model and a reactive APB slave.
// Revision : 1.0 - initial release
// ============================================================================
module tb_timer_apb_arbiter;

    localparam int TIMEOUT = 16;

    typedef struct {
        bit         id;
        bit         wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        bit         first;
        int         start;
    } xfer_t;

    logic       clk = 1'b0;
    logic       preset;
    logic       req0_valid, req0_write, req1_valid, req1_write;
    logic [7:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
    logic       req0_done, req0_err, req1_done, req1_err;
    logic [7:0] req0_rdata, req1_rdata;
    logic       psel, penable, pwrite, pready, busy, grant_id;
    logic [7:0] paddr, pwdata, prdata;

    int    n_checks = 0;
    int    n_pass   = 0;
    int    cyc      = 0;
    int    wait_fixed = 0;
    int    cur_wait = 0;
    int    acc_cnt  = 0;
    int    setup_cnt = 0;
    int    idle_run = 0;
    bit    b2b      = 0;
    bit    prev_done = 0;
    bit    last_win = 1;
    bit    force_data = 0;
    logic [7:0] force_val = 8'h00;
    logic [7:0] cap = 8'h00;
    xfer_t q[$];

    timer_apb_arbiter #(.ADDR_W(8), .DATA_W(8), .TIMEOUT_CYC(TIMEOUT)) dut (
        .pclk(clk), .preset(preset),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_done(req0_done), .req0_rdata(req0_rdata),
        .req0_err(req0_err),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_done(req1_done), .req1_rdata(req1_rdata),
        .req1_err(req1_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata), .pready(pready),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic handle_done();
        xfer_t h;
        int    exp_acc;
        bit    exp_err;
        logic [7:0] exp_rd;
        if (q.size() == 0) begin
            check("spurious_done", {30'd0, req1_done, req0_done}, 32'd0);
            return;
        end
        h = q.pop_front();
`ifdef TIMER_ARB_TIMEOUT_EN
        exp_err = (cur_wait >= TIMEOUT);
        exp_acc = exp_err ? TIMEOUT : cur_wait + 1;
`else
        exp_err = 1'b0;
        exp_acc = cur_wait + 1;
`endif
        exp_rd = (exp_err || h.wr) ? 8'h00 : cap;
        check("done_id", {30'd0, req1_done, req0_done}, h.id ? 32'd2 : 32'd1);
        check("done_pulse_width", {31'd0, prev_done}, 32'd0);
        check("rdata", h.id ? req1_rdata : req0_rdata, exp_rd);
        check("rdata_other", h.id ? req0_rdata : req1_rdata, 32'd0);
        check("err", {31'd0, h.id ? req1_err : req0_err}, {31'd0, exp_err});
        check("access_cycles", acc_cnt, exp_acc);
        check("setup_cycles", setup_cnt, 32'd1);
        if (h.first) check("latency", cyc - h.start, 2 + exp_acc);
        setup_cnt = 0;
        b2b = (q.size() > 0);
        if (h.id) req1_valid = 1'b0;
        else      req0_valid = 1'b0;
    endtask

    // One clock: observe at the falling edge, then drive the next inputs.
    task automatic advance();
        logic acc, stp;
        @(negedge clk);
        cyc++;
        acc = psel && penable;
        stp = psel && !penable;
        if (stp) begin
            if (b2b) check("b2b_gap", idle_run, 32'd2);
            b2b = 0;
            setup_cnt++;
            acc_cnt = 0;
            cur_wait = (wait_fixed >= 0) ? wait_fixed : int'($urandom_range(0, 3));
        end
        idle_run = psel ? 0 : idle_run + 1;
        if (acc && q.size() > 0)
            check("apb_fields", {13'd0, busy, grant_id, pwrite, paddr, pwdata},
                  {13'd0, 1'b1, q[0].id, q[0].wr, q[0].addr, q[0].wdata});
        if (req0_done || req1_done) handle_done();
        else check("quiet_outputs", {14'd0, req0_rdata, req1_rdata, req0_err, req1_err}, 32'd0);
        prev_done = req0_done | req1_done;
        if (acc) begin
            acc_cnt++;
            pready = (acc_cnt > cur_wait);
            prdata = force_data ? force_val : 8'($urandom);
            if (pready) cap = prdata;
        end else begin
            pready = 1'($urandom);
            prdata = 8'($urandom);
        end
        if (!req0_valid) begin
            req0_write = 1'($urandom); req0_addr = 8'($urandom); req0_wdata = 8'($urandom);
        end
        if (!req1_valid) begin
            req1_write = 1'($urandom); req1_addr = 8'($urandom); req1_wdata = 8'($urandom);
        end
    endtask

    task automatic run_round(input logic [1:0] mask,
                             input logic w0, input logic [7:0] a0, input logic [7:0] d0,
                             input logic w1, input logic [7:0] a1, input logic [7:0] d1);
        xfer_t t0, t1;
        int    n;
        t0.id = 0; t0.wr = w0; t0.addr = a0; t0.wdata = d0; t0.first = 0; t0.start = cyc;
        t1.id = 1; t1.wr = w1; t1.addr = a1; t1.wdata = d1; t1.first = 0; t1.start = cyc;
        if (mask[0]) begin req0_valid = 1; req0_write = w0; req0_addr = a0; req0_wdata = d0; end
        if (mask[1]) begin req1_valid = 1; req1_write = w1; req1_addr = a1; req1_wdata = d1; end
        if (mask == 2'b11) begin
            if (last_win) begin t0.first = 1; q.push_back(t0); q.push_back(t1); end
            else          begin t1.first = 1; q.push_back(t1); q.push_back(t0); end
        end else if (mask[0]) begin
            t0.first = 1; q.push_back(t0); last_win = 0;
        end else begin
            t1.first = 1; q.push_back(t1); last_win = 1;
        end
        n = 0;
        while (q.size() > 0 && n < 300) begin
            advance();
            n++;
        end
        check("round_complete", q.size(), 32'd0);
        if (q.size() > 0) begin
            q.delete();
            req0_valid = 0;
            req1_valid = 0;
        end
        advance();
    endtask

    initial begin
        xfer_t t;
        int    n;
        preset = 1; pready = 0; prdata = 0;
        req0_valid = 0; req0_write = 0; req0_addr = 0; req0_wdata = 0;
        req1_valid = 0; req1_write = 0; req1_addr = 0; req1_wdata = 0;
        repeat (3) advance();
        check("rst_apb", {29'd0, psel, penable, pwrite}, 32'd0);
        check("rst_addr_data", {16'd0, paddr, pwdata}, 32'd0);
        check("rst_busy_grant", {30'd0, busy, grant_id}, 32'd0);
        check("rst_done", {30'd0, req0_done, req1_done}, 32'd0);
        preset = 0;
        advance();

        wait_fixed = 0;
        run_round(2'b01, 1'b1, 8'h00, 8'h5A, 1'b0, 8'h00, 8'h00);

        wait_fixed = 3; force_data = 1; force_val = 8'h3C;
        run_round(2'b10, 1'b0, 8'h00, 8'h00, 1'b0, 8'h02, 8'h00);
        force_data = 0;

        wait_fixed = 0;
        run_round(2'b11, 1'b1, 8'h01, 8'hA1, 1'b1, 8'h03, 8'hB3);
        run_round(2'b11, 1'b0, 8'h01, 8'h00, 1'b0, 8'h03, 8'h00);

        // Reset during the ACCESS phase of a req0 write.
        req0_valid = 1; req0_write = 1; req0_addr = 8'h10; req0_wdata = 8'hA5;
        t.id = 0; t.wr = 1; t.addr = 8'h10; t.wdata = 8'hA5; t.first = 0; t.start = cyc;
        q.push_back(t);
        n = 0;
        while (!(psel && penable) && n < 20) begin
            advance();
            n++;
        end
        check("reached_access", {30'd0, psel, penable}, 32'd3);
        preset = 1;
        req0_valid = 0;
        advance();
        check("rst_mid_xfer", {29'd0, psel, penable, req0_done}, 32'd0);
        q.delete();
        preset = 0; last_win = 1; b2b = 0; setup_cnt = 0; acc_cnt = 0;
        advance();
        advance();
        check("post_rst_idle", {30'd0, busy, req0_done}, 32'd0);
        run_round(2'b10, 1'b0, 8'h00, 8'h00, 1'b1, 8'h21, 8'h77);
        last_win = 1;
        run_round(2'b11, 1'b0, 8'h05, 8'h00, 1'b1, 8'h06, 8'h66);

`ifdef TIMER_ARB_TIMEOUT_EN
        wait_fixed = 1000;
        run_round(2'b01, 1'b0, 8'h04, 8'h00, 1'b0, 8'h00, 8'h00);
        wait_fixed = TIMEOUT - 1;
        run_round(2'b10, 1'b0, 8'h00, 8'h00, 1'b0, 8'h08, 8'h00);
`else
        // Slave never ready: the transfer must hang in ACCESS with no done.
        wait_fixed = 1000000;
        req0_valid = 1; req0_write = 0; req0_addr = 8'h07; req0_wdata = 8'h00;
        t.id = 0; t.wr = 0; t.addr = 8'h07; t.wdata = 8'h00; t.first = 1; t.start = cyc;
        q.push_back(t);
        last_win = 0;
        repeat (3) advance();
        for (int i = 0; i < 100; i++) begin
            advance();
            check("stall_state", {28'd0, busy, psel, penable, req0_done}, 32'he);
        end
        cur_wait = acc_cnt;
        n = 0;
        while (q.size() > 0 && n < 20) begin
            advance();
            n++;
        end
        check("stall_release", q.size(), 32'd0);
        q.delete();
        advance();
`endif

        wait_fixed = -1;
        for (int r = 0; r < 40; r++) begin
            run_round(2'($urandom_range(1, 3)),
                      1'($urandom), 8'($urandom), 8'($urandom),
                      1'($urandom), 8'($urandom), 8'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/timer_apb_arbiter.md
Name: timer_apb_arbiter

Overview:
- Two-requester APB master arbiter that shares the single APB slave port of timer_top between two register-access clients, e.g. the CPU bridge (req0) and an auto-reload/config sequencer (req1).
- Accepts simple valid/done register transactions, arbitrates round-robin, and drives one APB transfer at a time (SETUP then ACCESS, wait on pready).
- Sits between the clients and timer_top, in the pclk domain.

Parameters:
- ADDR_W, 8, APB address width (paddr, reqN_addr).
- DATA_W, 8, APB data width (pwdata, prdata, reqN_wdata, reqN_rdata).
- TIMEOUT_CYC, 16, ACCESS-phase wait limit; used only when TIMER_ARB_TIMEOUT_EN is defined. Legal range 2..255.

Ports:
- pclk  in  1  single clock; all logic on its rising edge.
- preset  in  1  reset, synchronous, active-high.
- req0_valid  in  1  client 0 transaction request; held high until req0_done.
- req0_write  in  1  1 = write, 0 = read; stable while req0_valid.
- req0_addr  in  ADDR_W  register address.
- req0_wdata  in  DATA_W  write data.
- req0_done  out  1  one-cycle completion pulse.
- req0_rdata  out  DATA_W  read data, valid only while req0_done=1.
- req0_err  out  1  timeout flag, valid with req0_done.
- req1_valid, req1_write, req1_addr, req1_wdata, req1_done, req1_rdata, req1_err: same as the req0 group, for client 1.
- psel  out  1  APB select to timer_top.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- prdata  in  DATA_W  APB read data.
- pready  in  1  APB ready from timer_top.
- busy  out  1  high in every state except IDLE.
- grant_id  out  1  client owning the current or last transfer.

Behaviour:
- Synchronous, active-high reset. On reset: FSM to IDLE; psel, penable, pwrite, paddr, pwdata, all done/err/rdata outputs, busy and grant_id = 0; round-robin pointer set so req0 wins the first contention.
- A reset asserted mid-transfer drops psel/penable on the next edge. The in-flight transaction is abandoned and no done is issued.
- FSM states: IDLE, SETUP, ACCESS, DONE.
- IDLE: if any reqN_valid, grant that client. Contention (both valid) goes to the client not granted last. On the grant edge, latch write/addr/wdata into the APB output registers, set grant_id, go to SETUP.
- SETUP: psel=1, penable=0 for exactly one cycle, then go to ACCESS.
- ACCESS: psel=1, penable=1.
  - pready=0: stay in ACCESS.
  - pready=1: capture prdata (reads only; writes leave the rdata register at 0), then go to DONE.
- DONE: psel=penable=0. reqN_done=1 for one cycle, only for the granted client. reqN_rdata carries the captured data and the other client's outputs stay 0. Then go to IDLE.
- Latency with pready already high: valid sampled in IDLE at edge T; SETUP in T+1, ACCESS in T+2, done high in T+3. Minimum 4 cycles per transfer; back-to-back transfers start with IDLE immediately after DONE.
- Client rule: the client deasserts valid on the same edge that samples done=1, and may reassert it from the following cycle.
- Fairness with both clients continuously valid: grants alternate 0,1,0,1.
- paddr, pwdata and pwrite are held constant from SETUP through ACCESS.
- Outside SETUP/ACCESS they keep their last value; psel is 0 there.
- Changes on a non-granted client's inputs during a transfer have no effect.
- reqN_rdata and reqN_err return to 0 after the done cycle.

Optional Feature:
- Macro: TIMER_ARB_TIMEOUT_EN.
- Defined: an 8-bit wait counter clears on entry to ACCESS and increments each ACCESS cycle with pready=0.
  - Reaching TIMEOUT_CYC with pready=0 moves the FSM to DONE with reqN_err=1 and reqN_rdata=0, and psel drops.
  - pready=1 in that same cycle takes priority: normal completion, err=0.
- Not defined: no counter; ACCESS waits indefinitely; reqN_err tied to 0.

Test Plan:
- Reset, then req0 writes addr 0x00 data 0x5A with pready=1 -> one SETUP, then one ACCESS cycle with paddr=0x00, pwdata=0x5A, pwrite=1; req0_done at T+3; req0_err=0.
- req1 reads addr 0x02; slave returns 0x3C after 3 wait cycles -> penable high for 4 cycles; req1_done with req1_rdata=0x3C; req0_done stays 0.
- Both clients valid continuously for 4 transactions (req0 addr 0x01, req1 addr 0x03) -> grant order 0,1,0,1; each done pulse exactly one cycle; psel=0 for exactly 2 cycles (DONE, IDLE) between transfers.
- preset asserted during ACCESS of a req0 write -> psel=penable=0 on the next edge, no req0_done; after release, a req1 request is served first transfer 0-ready (round-robin pointer reset; req1 alone still granted).
- Macro defined, TIMEOUT_CYC=16, pready held 0 -> transfer aborts after 16 ACCESS cycles; done with err=1, rdata=0x00. With pready=1 in cycle 16 -> normal done, err=0.
- Macro undefined, pready held 0 for 100 cycles -> FSM stays in ACCESS, busy=1, no done.
